baud_tick_gen: RTL and testbench

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

---
 rtl/baud_tick_gen_pkg.sv | 18 +
 rtl/baud_tick_gen_frac_accum.sv | 30 +++
 rtl/baud_tick_gen.sv | 102 ++++++++++
 tb/tb_baud_tick_gen.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baud_tick_gen_pkg.sv
// Shared constants for the fractional baud tick generator: reset defaults,
// system clock rate and precomputed divisors for common baud rates at 16x.
package baud_tick_gen_pkg;

  localparam int CLK_HZ       = 100_000_000;
  localparam int OSR_DEF      = 16;
  localparam int DIV_RST_DEF  = 651;
  localparam int FRAC_RST_DEF = 1;

  // Divisor = CLK_HZ / (baud * 16), split into integer and 1/16 parts (rounded).
  localparam int DIV_9600    = 651;
  localparam int FRAC_9600   = 1;
  localparam int DIV_19200   = 325;
  localparam int FRAC_19200  = 8;
  localparam int DIV_115200  = 54;
  localparam int FRAC_115200 = 4;

endpackage

// File: rtl/baud_tick_gen_frac_accum.sv
// Fractional phase accumulator: adds the active fraction once per period and
// reports the carry that stretches that period by one cycle.
module frac_accum #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              clear,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, frac};
  assign carry = sum[FRAC_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Fractional-N baud tick generator: oversample strobe, bit strobe and baud
// square wave with glitch-free divisor updates at period boundaries.
module baud_tick_gen
  import baud_tick_gen_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR      = OSR_DEF,
  parameter int DIV_RST  = DIV_RST_DEF,
  parameter int FRAC_RST = FRAC_RST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              resync,
  output logic              tick_os,
  output logic              tick_bit,
  output logic              baud_sq,
  output logic              div_pending,
  output logic              div_err
);

  localparam int IDX_W = (OSR > 1) ? $clog2(OSR) : 1;

  logic [DIV_W-1:0]  cnt;
  logic [IDX_W-1:0]  os_idx;
  logic [DIV_W-1:0]  act_int, sh_int, sh_int_nxt, int_use;
  logic [FRAC_W-1:0] act_frac, sh_frac, sh_frac_nxt, frac_use;
  logic              load_ok, pend_nxt, reload, apply, carry;
  logic [DIV_W-1:0]  period_m1, half_m1;

  assign load_ok     = div_load && (div_int >= DIV_W'(2));
  assign sh_int_nxt  = load_ok ? div_int : sh_int;
  assign sh_frac_nxt = load_ok ? div_frac : sh_frac;
  assign pend_nxt    = load_ok || div_pending;
  assign reload      = en && (cnt == '0) && !resync;

  // A waiting divisor is adopted at a reload, on resync (before the half
  // period is computed), or straight away while counting is disabled.
  assign apply    = pend_nxt && (reload || resync || !en);
  assign int_use  = apply ? sh_int_nxt : act_int;
  assign frac_use = apply ? sh_frac_nxt : act_frac;

  // int_use is never below 2, so neither expression can underflow.
  assign period_m1 = int_use - DIV_W'(1) + DIV_W'(carry);
  assign half_m1   = (int_use >> 1) - DIV_W'(1);

  frac_accum #(
    .FRAC_W (FRAC_W)
  ) u_frac_accum (
    .clk   (clk),
    .reset (reset),
    .step  (reload),
    .clear (resync),
    .frac  (frac_use),
    .carry (carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= DIV_W'(DIV_RST - 1);
      os_idx      <= '0;
      act_int     <= DIV_W'(DIV_RST);
      act_frac    <= FRAC_W'(FRAC_RST);
      sh_int      <= DIV_W'(DIV_RST);
      sh_frac     <= FRAC_W'(FRAC_RST);
      div_pending <= 1'b0;
      div_err     <= 1'b0;
      tick_os     <= 1'b0;
      tick_bit    <= 1'b0;
      baud_sq     <= 1'b0;
    end else begin
      tick_os  <= reload;
      tick_bit <= reload && (os_idx == IDX_W'(OSR - 1));
      sh_int   <= sh_int_nxt;
      sh_frac  <= sh_frac_nxt;
      if (div_load && !load_ok) begin
        div_err <= 1'b1;
      end
      if (apply) begin
        act_int  <= sh_int_nxt;
        act_frac <= sh_frac_nxt;
      end
      div_pending <= pend_nxt && !apply;

      if (resync) begin
        cnt    <= half_m1;
        os_idx <= '0;
      end else if (reload) begin
        cnt     <= period_m1;
        os_idx  <= (os_idx == IDX_W'(OSR - 1)) ? '0 : os_idx + IDX_W'(1);
        baud_sq <= ~baud_sq;
      end else if (en) begin
        cnt <= cnt - DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: a tick-time reference model queues the
// expected strobes, an independent monitor pops and compares them.
module tb_baud_tick_gen;

  localparam int OSR = 16;

  logic        clk = 1'b0;
  logic        reset, en, div_load, resync;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        tick_os, tick_bit, baud_sq, div_pending, div_err;

  baud_tick_gen dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .div_load    (div_load),
    .resync      (resync),
    .tick_os     (tick_os),
    .tick_bit    (tick_bit),
    .baud_sq     (baud_sq),
    .div_pending (div_pending),
    .div_err     (div_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int e;
    bit b;
    bit sq;
  } ev_t;

  ev_t q[$];
  int  dut_t[$];

  // Reference model: tracks the absolute edge of the next tick and the
  // fractional phase in 1/16 units, rather than any counter.
  int edge_n = 0;
  int nt = 0;
  int act_i, act_f, sh_i, sh_f, phase, nticks;
  bit m_pend = 0, m_err = 0, m_sq = 0;
  bit ok, pe, tk, ap;
  int si, sf;

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      nt = edge_n + 651;
      act_i = 651; act_f = 1; sh_i = 651; sh_f = 1;
      m_pend = 0; m_err = 0; m_sq = 0; phase = 0; nticks = 0;
      q.delete();
    end else begin
      ok = div_load && (int'(div_int) >= 2);
      if (div_load && !ok) m_err = 1;
      si = ok ? int'(div_int) : sh_i;
      sf = ok ? int'(div_frac) : sh_f;
      pe = m_pend || ok;
      tk = en && (edge_n == nt) && !resync;
      ap = pe && (tk || resync || !en);
      if (ap) begin
        act_i = si; act_f = sf;
      end
      sh_i = si; sh_f = sf;
      m_pend = pe && !ap;
      if (resync) begin
        nt = edge_n + act_i / 2;
        phase = 0;
        nticks = 0;
      end else if (tk) begin
        phase = phase + act_f;
        nt = edge_n + act_i + ((phase >= 16) ? 1 : 0);
        phase = phase % 16;
        m_sq = !m_sq;
        q.push_back('{edge_n, (nticks % OSR) == OSR - 1, m_sq});
        nticks++;
      end else if (!en) begin
        nt++;
      end
    end
  end

  // Monitor: compares on every DUT strobe, plus the level flags each cycle.
  ev_t ev;
  always @(negedge clk) begin
    if (!reset) begin
      while (q.size() > 0 && q[0].e < edge_n) begin
        vectors++; miscompares++;
        $display("FAIL missed_tick: got none, expected tick at edge %0d (now %0d)", q[0].e, edge_n);
        void'(q.pop_front());
      end
      if (tick_os) begin
        dut_t.push_back(edge_n);
        vectors++;
        if (q.size() == 0 || q[0].e != edge_n) begin
          miscompares++;
          $display("FAIL tick_time: got tick at edge %0d, expected %0d", edge_n,
                   (q.size() > 0) ? q[0].e : -1);
        end else begin
          ev = q.pop_front();
          vectors += 2;
          if (tick_bit != ev.b) begin
            miscompares++;
            $display("FAIL tick_bit: got %0d expected %0d at edge %0d", tick_bit, ev.b, edge_n);
          end
          if (baud_sq != ev.sq) begin
            miscompares++;
            $display("FAIL baud_sq: got %0d expected %0d at edge %0d", baud_sq, ev.sq, edge_n);
          end
        end
      end else if (tick_bit) begin
        vectors++; miscompares++;
        $display("FAIL tick_bit_alone: got 1 expected 0 at edge %0d", edge_n);
      end
      vectors += 2;
      if (div_pending != m_pend) begin
        miscompares++;
        $display("FAIL div_pending: got %0d expected %0d at edge %0d", div_pending, m_pend, edge_n);
      end
      if (div_err != m_err) begin
        miscompares++;
        $display("FAIL div_err: got %0d expected %0d at edge %0d", div_err, m_err, edge_n);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic int tk_at(input int i);
    return (i >= 0 && i < dut_t.size()) ? dut_t[i] : -1;
  endfunction

  task automatic wait_ticks(input int n, input int budget);
    int start = dut_t.size();
    int k = 0;
    while (dut_t.size() < start + n && k < budget) begin
      step();
      k++;
    end
    if (dut_t.size() < start + n) chk("tick_timeout", dut_t.size() - start, n);
  endtask

  int b, rel, rs, n651, n652, guard;

  initial begin
    reset = 1; en = 0; div_load = 0; resync = 0; div_int = '0; div_frac = '0;
    step(3);
    chk("rst_tick_os", tick_os, 0);
    chk("rst_tick_bit", tick_bit, 0);
    chk("rst_baud_sq", baud_sq, 0);
    chk("rst_pending", div_pending, 0);
    chk("rst_err", div_err, 0);

    // Defaults: 17 ticks, fifteen 651 periods and one 652 period
    rel = edge_n;
    reset = 0; en = 1;
    b = dut_t.size();
    wait_ticks(17, 12000);
    chk("first_tick_after_reset", tk_at(b) - rel, 651);
    chk("sixteen_periods_sum", tk_at(b + 16) - tk_at(b), 10417);
    n651 = 0; n652 = 0;
    for (int i = 0; i < 16; i++) begin
      if (tk_at(b + i + 1) - tk_at(b + i) == 651) n651++;
      if (tk_at(b + i + 1) - tk_at(b + i) == 652) n652++;
    end
    chk("periods_651", n651, 15);
    chk("periods_652", n652, 1);

    // Mid-period divisor change to 10
    step($urandom_range(50, 300));
    div_int = 16'd10; div_frac = 4'd0; div_load = 1;
    step();
    div_load = 0;
    chk("pending_after_load", div_pending, 1);
    b = dut_t.size();
    wait_ticks(3, 800);
    chk("pending_cleared", div_pending, 0);
    chk("old_period_kept", tk_at(b) - tk_at(b - 1), 651);
    chk("new_period_a", tk_at(b + 1) - tk_at(b), 10);
    chk("new_period_b", tk_at(b + 2) - tk_at(b + 1), 10);

    // Resync 100 cycles after a tick
    wait_ticks(1, 20);
    step(100);
    rs = edge_n + 1;
    resync = 1;
    step();
    resync = 0;
    b = dut_t.size();
    wait_ticks(3, 60);
    chk("resync_first_tick", tk_at(b) - rs, 5);
    chk("resync_spacing", tk_at(b + 1) - tk_at(b), 10);

    // Illegal divisor
    div_int = 16'd1; div_frac = 4'd3; div_load = 1;
    step();
    div_load = 0;
    chk("err_set", div_err, 1);
    chk("err_no_pending", div_pending, 0);
    b = dut_t.size();
    wait_ticks(2, 40);
    chk("period_unchanged", tk_at(b + 1) - tk_at(b), 10);

    // Enable low 50 cycles mid-period
    wait_ticks(1, 20);
    step(3);
    en = 0;
    step(50);
    en = 1;
    b = dut_t.size();
    wait_ticks(1, 40);
    chk("en_hold_period", tk_at(b) - tk_at(b - 1), 60);

    // Resync coincident with the terminal count
    guard = 0;
    while (nt != edge_n + 1 && guard < 30) begin
      step();
      guard++;
    end
    rs = edge_n + 1;
    resync = 1;
    step();
    resync = 0;
    b = dut_t.size();
    wait_ticks(1, 30);
    chk("coincident_resync_tick", tk_at(b) - rs, 5);

    // Resync together with a load uses the new divisor
    div_int = 16'd20; div_frac = 4'd0; div_load = 1; resync = 1;
    rs = edge_n + 1;
    step();
    div_load = 0; resync = 0;
    b = dut_t.size();
    wait_ticks(2, 60);
    chk("resync_load_first", tk_at(b) - rs, 10);
    chk("resync_load_period", tk_at(b + 1) - tk_at(b), 20);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 19) == 0);
      div_int = 16'($urandom_range(0, 24));
      div_frac = 4'($urandom_range(0, 15));
      resync = ($urandom_range(0, 59) == 0);
      step();
    end
    en = 1; div_load = 0; resync = 0;
    step(60);

    // Reset mid-period
    wait_ticks(1, 60);
    step(3);
    #1 reset = 1;
    #1;
    chk("async_rst_tick_os", tick_os, 0);
    chk("async_rst_baud_sq", baud_sq, 0);
    chk("async_rst_pending", div_pending, 0);
    chk("async_rst_err", div_err, 0);
    step();
    rel = edge_n;
    reset = 0;
    b = dut_t.size();
    wait_ticks(1, 800);
    chk("tick_after_reset_release", tk_at(b) - rel, 651);

    step(20);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
